// File: rtl/pipe_stage_chain_pkg.sv
// pipe_pkg: shared mode constants, occupancy width helper and slot template for pipeline stages
package pipe_pkg;
  localparam int PIPE_RIGID = 0;
  localparam int PIPE_COLLAPSE = 1;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef struct packed {
    logic        valid;
    logic [15:0] ctrl;
    logic [63:0] data;
  } pipe_slot_t;
endpackage

// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: upstream/downstream handshake and status bundle of the stage chain
interface pipe_stage_chain_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 2
);
  logic                                in_valid;
  logic [CTRL_W-1:0]                   in_ctrl;
  logic [DATA_W-1:0]                   in_data;
  logic                                in_ready;
  logic                                stall;
  logic [DEPTH-1:0]                    flush;
  logic                                out_valid;
  logic [CTRL_W-1:0]                   out_ctrl;
  logic [DATA_W-1:0]                   out_data;
  logic [pipe_pkg::occ_w(DEPTH)-1:0]   occupancy;
  modport master (output in_valid, in_ctrl, in_data, stall, flush,
                  input in_ready, out_valid, out_ctrl, out_data, occupancy);
  modport slave  (input in_valid, in_ctrl, in_data, stall, flush,
                  output in_ready, out_valid, out_ctrl, out_data, occupancy);
endinterface

// File: rtl/pipe_stage_chain_slot.sv
// pipe_slot: one pipeline slot with load/hold/flush selection and async reset
module pipe_slot #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              flush,
  input  logic              src_valid,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic [DATA_W-1:0] src_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic              nxt_valid
);
  logic              v_d, v_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;
  // flush beats load beats hold; bubbles never carry control bits
  always_comb begin
    v_d    = flush ? 1'b0 : go ? src_valid : v_q;
    ctrl_d = flush ? '0 : go ? (src_valid ? src_ctrl : '0) : ctrl_q;
    data_d = (flush && CLEAR_DATA != 0) ? '0 : go ? src_data : data_q;
  end
  // slot registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end
  assign q_valid   = v_q;
  assign q_ctrl    = ctrl_q;
  assign q_data    = data_q;
  assign nxt_valid = v_d;
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-slot pipeline register chain with flush, stall and optional bubble collapse
module pipe_stage_chain import pipe_pkg::*; #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16,
  parameter int DEPTH      = 2,
  parameter int COLLAPSE   = PIPE_RIGID,
  parameter int CLEAR_DATA = 1
) (
  input logic              clk,
  input logic              rst_n,
  pipe_stage_chain_if.slave bus
);
  localparam int OW = occ_w(DEPTH);
  logic [DEPTH-1:0]  go, v, nv;
  logic [CTRL_W-1:0] ctrl [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [OW-1:0]     occ_d, occ_q;
  // capture enables: rigid freezes everything on stall, collapse lets slots fill their bubbles
  always_comb begin
    go[DEPTH-1] = !bus.stall || (COLLAPSE != 0 && !v[DEPTH-1]);
    for (int i = DEPTH - 2; i >= 0; i--)
      go[i] = (COLLAPSE != 0) ? (go[i+1] || !v[i]) : !bus.stall;
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic              sv;
    logic [CTRL_W-1:0] sc;
    logic [DATA_W-1:0] sd;
    if (g == 0) begin : g_head
      assign sv = bus.in_valid;
      assign sc = bus.in_ctrl;
      assign sd = bus.in_data;
    end else begin : g_body
      assign sv = v[g-1];
      assign sc = ctrl[g-1];
      assign sd = data[g-1];
    end
    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_slot (
      .clk(clk), .rst_n(rst_n), .go(go[g]), .flush(bus.flush[g]),
      .src_valid(sv), .src_ctrl(sc), .src_data(sd),
      .q_valid(v[g]), .q_ctrl(ctrl[g]), .q_data(data[g]), .nxt_valid(nv[g])
    );
  end
  // occupancy tracks the popcount of the next-state valid bits
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + OW'(nv[i]);
  end
  // registered occupancy, cleared with the slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else occ_q <= occ_d;
  end
  assign bus.in_ready  = go[0];
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_ctrl  = ctrl[DEPTH-1];
  assign bus.out_data  = data[DEPTH-1];
  assign bus.occupancy = occ_q;
endmodule
